// File: rtl/op_sequencer.sv
// op_sequencer: programmable ALU/shifter op sequencer.
// Steps through a writable NUM_STEPS-entry {alu_op, shift_op} table and repeats it
// loop_count times (0 = until abort). Provides start/busy/done handshake, stall and abort.
// Optional feature macro: OPSEQ_CFG_READBACK_EN adds the combinational cfg_rdata port.
module op_sequencer #(
  parameter int unsigned NUM_STEPS  = 4,
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned SHIFT_OP_W = 2,
  parameter int unsigned LOOP_W     = 8,
  localparam int unsigned SW        = $clog2(NUM_STEPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LOOP_W-1:0]     loop_count,
  input  logic                  stall,
  input  logic                  abort,
  input  logic                  cfg_we,
  input  logic [SW-1:0]         cfg_addr,
  input  logic [ALU_OP_W-1:0]   cfg_alu_op,
  input  logic [SHIFT_OP_W-1:0] cfg_shift_op,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [SHIFT_OP_W-1:0] shift_op,
  output logic                  op_valid,
  output logic [SW-1:0]         step,
  output logic [LOOP_W-1:0]     loop_idx,
  output logic                  busy,
  output logic                  done
`ifdef OPSEQ_CFG_READBACK_EN
  ,
  output logic [ALU_OP_W+SHIFT_OP_W-1:0] cfg_rdata
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       step_q, step_d;
  logic [LOOP_W-1:0]   loop_idx_q, loop_idx_d;
  logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;

  logic [ALU_OP_W-1:0]   tbl_alu_q [NUM_STEPS];
  logic [SHIFT_OP_W-1:0] tbl_sh_q  [NUM_STEPS];

  logic addr_ok;
  logic cfg_hit;

  // Non-power-of-two depths leave unused addresses; those are ignored.
  assign addr_ok = (32'(cfg_addr) < NUM_STEPS);
  assign cfg_hit = (state_q == StIdle) && cfg_we && addr_ok;

  // State, step, pass counter and latched loop_count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      step_q     <= '0;
      loop_idx_q <= '0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      loop_idx_q <= loop_idx_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  // Op table: reset restores the identity sequence; writes only land while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        tbl_alu_q[i] <= ALU_OP_W'(i);
        tbl_sh_q[i]  <= SHIFT_OP_W'(i);
      end
    end else if (cfg_hit) begin
      tbl_alu_q[cfg_addr] <= cfg_alu_op;
      tbl_sh_q[cfg_addr]  <= cfg_shift_op;
    end
  end

  // Next-state: abort beats stall, stall beats advance/completion.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    loop_idx_d = loop_idx_q;
    loop_cnt_d = loop_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          step_d     = '0;
          loop_idx_d = '0;
          loop_cnt_d = loop_count;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!stall) begin
          if (step_q == SW'(NUM_STEPS - 1)) begin
            step_d     = '0;
            loop_idx_d = loop_idx_q + LOOP_W'(1);
            if ((loop_cnt_q != '0) && (loop_idx_d == loop_cnt_q)) begin
              state_d = StDone;
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode from state/step/table; idle and done present the all-ones NOP.
  always_comb begin
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    op_valid = busy && !stall;
    step     = step_q;
    loop_idx = loop_idx_q;
    alu_op   = '1;
    shift_op = '0;
    if (busy) begin
      alu_op   = tbl_alu_q[step_q];
      shift_op = tbl_sh_q[step_q];
    end
  end

`ifdef OPSEQ_CFG_READBACK_EN
  // Readback of the addressed table entry, zero when out of range.
  always_comb begin
    cfg_rdata = '0;
    if (addr_ok) begin
      cfg_rdata = {tbl_alu_q[cfg_addr], tbl_sh_q[cfg_addr]};
    end
  end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: run-level reference model (ops issued per run) plus directed
// scenarios with literal expectations and a randomized phase.
module tb_op_sequencer;
  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned SHW = 2;
  localparam int unsigned LW  = 8;
  localparam int unsigned SW  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [LW-1:0]  loop_count = '0;
  logic           stall = 1'b0;
  logic           abort = 1'b0;
  logic           cfg_we = 1'b0;
  logic [SW-1:0]  cfg_addr = '0;
  logic [AW-1:0]  cfg_alu_op = '0;
  logic [SHW-1:0] cfg_shift_op = '0;
  logic [AW-1:0]  alu_op;
  logic [SHW-1:0] shift_op;
  logic           op_valid;
  logic [SW-1:0]  step;
  logic [LW-1:0]  loop_idx;
  logic           busy;
  logic           done;
`ifdef OPSEQ_CFG_READBACK_EN
  logic [AW+SHW-1:0] cfg_rdata;
`endif

  op_sequencer #(
    .NUM_STEPS (N),
    .ALU_OP_W  (AW),
    .SHIFT_OP_W(SHW),
    .LOOP_W    (LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .loop_count  (loop_count),
    .stall       (stall),
    .abort       (abort),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_alu_op  (cfg_alu_op),
    .cfg_shift_op(cfg_shift_op),
    .alu_op      (alu_op),
    .shift_op    (shift_op),
    .op_valid    (op_valid),
    .step        (step),
    .loop_idx    (loop_idx),
    .busy        (busy),
    .done        (done)
`ifdef OPSEQ_CFG_READBACK_EN
    ,
    .cfg_rdata   (cfg_rdata)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is described by how many ops it has issued (m_n).
  // step = m_n mod N, loop_idx = m_n div N; the run ends once m_n reaches cnt*N.
  int         m_mode;  // 0 idle, 1 running, 2 done-pulse cycle
  int         m_n;
  int         m_cnt;
  logic [3:0] m_alu [N];
  logic [1:0] m_sh  [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0;
      m_n    <= 0;
      m_cnt  <= 0;
      for (int i = 0; i < int'(N); i++) begin
        m_alu[i] <= 4'(i);
        m_sh[i]  <= 2'(i);
      end
    end else begin
      case (m_mode)
        0: begin
          if (cfg_we && int'(cfg_addr) < int'(N)) begin
            m_alu[cfg_addr] <= cfg_alu_op;
            m_sh[cfg_addr]  <= cfg_shift_op;
          end
          if (start) begin
            m_mode <= 1;
            m_n    <= 0;
            m_cnt  <= int'(loop_count);
          end
        end
        1: begin
          if (abort) begin
            m_mode <= 0;
          end else if (!stall) begin
            m_n <= m_n + 1;
            if (m_cnt != 0 && m_n + 1 == m_cnt * int'(N)) m_mode <= 2;
          end
        end
        default: m_mode <= 0;
      endcase
    end
  end

  logic [5:0] op_log[$];
  int         done_cnt = 0;
  int         hold_cnt = 0;

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    int  s;
    bit  run;
    s   = m_n % int'(N);
    run = (m_mode == 1);
    chk("busy", 32'(busy), 32'(run));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("op_valid", 32'(op_valid), 32'(run && !stall));
    chk("step", 32'(step), 32'(s));
    chk("loop_idx", 32'(loop_idx), 32'((m_n / int'(N)) % 256));
    chk("alu_op", 32'(alu_op), run ? 32'(m_alu[s]) : 32'hF);
    chk("shift_op", 32'(shift_op), run ? 32'(m_sh[s]) : 32'h0);
`ifdef OPSEQ_CFG_READBACK_EN
    chk("cfg_rdata", 32'(cfg_rdata), 32'({m_alu[cfg_addr], m_sh[cfg_addr]}));
`endif
    if (op_valid) op_log.push_back({alu_op, shift_op});
    if (done) done_cnt++;
    if (busy && !op_valid) hold_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    op_log.delete();
    done_cnt = 0;
    hold_cnt = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk({name, " done seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic wait_ops(input int n, input int budget, input string name);
    int c = 0;
    while (op_log.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk({name, " op count reached"}, 32'(op_log.size()), 32'(n));
  endtask

  task automatic chk_seq(input string name, input logic [5:0] e0, input logic [5:0] e1,
                         input logic [5:0] e2, input logic [5:0] e3, input int total);
    logic [5:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    chk({name, " op count"}, 32'(op_log.size()), 32'(total));
    for (int i = 0; i < total && i < op_log.size(); i++) begin
      chk($sformatf("%s op%0d", name, i), 32'(op_log[i]), 32'(exp[i % 4]));
    end
  endtask

  task automatic start_run(input logic [LW-1:0] cnt);
    loop_count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // 1: default table, one pass.
    clear_logs();
    start_run(8'd1);
    wait_done(20, "t1");
    chk_seq("t1", 6'h00, 6'h05, 6'h0A, 6'h0F, 4);
    chk("t1 done pulses", 32'(done_cnt), 32'd1);
    tick();
    chk("t1 busy after", 32'(busy), 32'd0);

    // 2: program table, three passes.
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1;
      cfg_addr = 2'(i);
      case (i)
        0: {cfg_alu_op, cfg_shift_op} = {4'hA, 2'd2};
        1: {cfg_alu_op, cfg_shift_op} = {4'h5, 2'd1};
        2: {cfg_alu_op, cfg_shift_op} = {4'hC, 2'd3};
        default: {cfg_alu_op, cfg_shift_op} = {4'h7, 2'd0};
      endcase
      tick();
    end
    cfg_we = 1'b0;
    clear_logs();
    start_run(8'd3);
    wait_done(40, "t2");
    chk("t2 loop_idx final", 32'(loop_idx), 32'd3);
    chk_seq("t2", {4'hA, 2'd2}, {4'h5, 2'd1}, {4'hC, 2'd3}, {4'h7, 2'd0}, 12);
    tick();
    tick();
    chk("t2 single done", 32'(done_cnt), 32'd1);

    // 3: stall three cycles at step 2.
    clear_logs();
    start_run(8'd1);
    tick();
    tick();
    stall = 1'b1;
    tick();
    chk("t3 step held", 32'(step), 32'd2);
    tick();
    tick();
    stall = 1'b0;
    wait_done(20, "t3");
    chk("t3 stalled cycles", 32'(hold_cnt), 32'd3);
    chk_seq("t3", {4'hA, 2'd2}, {4'h5, 2'd1}, {4'hC, 2'd3}, {4'h7, 2'd0}, 4);
    tick();

    // 4: endless run aborted after 10 ops.
    clear_logs();
    start_run(8'd0);
    wait_ops(10, 40, "t4");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4 busy", 32'(busy), 32'd0);
    chk("t4 alu_op", 32'(alu_op), 32'hF);
    chk("t4 op_valid", 32'(op_valid), 32'd0);
    tick();
    chk("t4 ops", 32'(op_log.size()), 32'd10);
    chk("t4 no done", 32'(done_cnt), 32'd0);

    // 5: writes and start during a run are dropped.
    clear_logs();
    loop_count = 8'd1;
    start = 1'b1;
    tick();
    cfg_we = 1'b1;
    cfg_addr = 2'd1;
    {cfg_alu_op, cfg_shift_op} = {4'h3, 2'd3};
    tick();
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    wait_done(20, "t5");
    repeat (3) tick();
    chk("t5 busy after", 32'(busy), 32'd0);
    chk("t5 single done", 32'(done_cnt), 32'd1);
    chk_seq("t5", {4'hA, 2'd2}, {4'h5, 2'd1}, {4'hC, 2'd3}, {4'h7, 2'd0}, 4);
`ifdef OPSEQ_CFG_READBACK_EN
    chk("t5 readback", 32'(cfg_rdata), 32'({4'h5, 2'd1}));
`endif

    // 6: reset mid-run at step 2, then defaults replay.
    clear_logs();
    start_run(8'd1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6 busy async", 32'(busy), 32'd0);
    chk("t6 step async", 32'(step), 32'd0);
    chk("t6 op_valid async", 32'(op_valid), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    clear_logs();
    start_run(8'd1);
    wait_done(20, "t6");
    chk_seq("t6", 6'h00, 6'h05, 6'h0A, 6'h0F, 4);

    // Randomized phase against the model.
    for (int i = 0; i < 2000; i++) begin
      start        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      cfg_we       = ($urandom_range(0, 4) == 0);
      loop_count   = LW'($urandom_range(0, 3));
      cfg_addr     = SW'($urandom);
      cfg_alu_op   = AW'($urandom);
      cfg_shift_op = SHW'($urandom);
      tick();
    end
    {start, stall, abort, cfg_we} = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
